btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, consecutive stable cycles required to accept a level change (5 ms at 50 MHz).
REQ-002 Parameter CNT_W, default 18, debounce counter width; DEBOUNCE_CYCLES SHALL satisfy 1 <= DEBOUNCE_CYCLES < 2^CNT_W.
REQ-003 clock  input  1  single system clock, rising-edge active.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_raw  input  3  raw board pushbuttons, active-low, asynchronous to clock.
REQ-006 btn  output  3  one-cycle press pulses, active-high, one bit per button; feeds the game FSM btn input.
REQ-007 btn_level  output  3  debounced button levels, active-high (1 = held).
REQ-008 multi_press  output  1  one-cycle pulse flagging a rejected simultaneous press.

Function
REQ-009 Each btn_raw bit SHALL pass through a 2-flop synchronizer and be inverted to active-high before any other use.
REQ-010 Each button SHALL have an independent counter: cleared when the synchronized value equals btn_level, incremented by 1 otherwise.
REQ-011 On the edge where the counter would reach DEBOUNCE_CYCLES, btn_level SHALL toggle and the counter SHALL clear in the same edge.
REQ-012 Any bounce (synchronized value returns to btn_level) before that edge SHALL clear the counter with no level change.
REQ-013 The counter SHALL never wrap; its maximum value is DEBOUNCE_CYCLES-1.
REQ-014 A candidate press is a 0->1 btn_level transition; releases (1->0) SHALL never produce btn or multi_press pulses.
REQ-015 btn pulses SHALL be registered and asserted in the same cycle btn_level rises; width exactly one cycle.
REQ-016 Latency: a clean raw press SHALL produce its btn pulse after exactly 2 + DEBOUNCE_CYCLES rising edges.
REQ-017 A held button SHALL produce exactly one pulse per press; no repeat while held.
REQ-018 btn SHALL be at most one-hot in every cycle in all configurations.
REQ-019 Without lock, candidate presses of two or more buttons in the same cycle SHALL suppress all btn pulses that cycle and assert multi_press for one cycle.

Reset
REQ-020 While reset is high, synchronizer flops SHALL hold the released value (1), counters 0, btn_level 3'b000, btn 3'b000, multi_press 0, asynchronously.
REQ-021 Reset asserted mid-debounce SHALL discard all progress; no pulse SHALL originate from pre-reset activity.
REQ-022 A button held through reset release SHALL be treated as a new press and pulse after 2 + DEBOUNCE_CYCLES edges.

Configuration
REQ-023 Macro BTN_ONEHOT_LOCK_EN, when defined, SHALL suppress the btn pulse of a candidate press if any other btn_level bit is already 1 in that cycle, and assert multi_press for one cycle instead.
REQ-024 With BTN_ONEHOT_LOCK_EN defined, pulses SHALL resume only for presses made after all other buttons are released (btn_level of others = 0).
REQ-025 Without BTN_ONEHOT_LOCK_EN, a press SHALL pulse regardless of other held buttons; only same-cycle presses follow REQ-019.

Verification (DEBOUNCE_CYCLES=4, CNT_W=3)
REQ-026 btn_raw[1] 1->0 clean, held 20 cycles -> btn=3'b010 for exactly one cycle, 6 edges after the change; btn_level[1]=1 from that edge; nothing on release.
REQ-027 btn_raw[0] toggles every 2 cycles for 12 cycles, then stays low -> no pulse during bounce; single btn=3'b001 pulse 6 edges after the final settle.
REQ-028 btn_raw[0] and btn_raw[2] pressed same edge -> btn stays 3'b000, multi_press pulses once at edge 6, btn_level=3'b101.
REQ-029 btn_raw[2] held, btn_raw[0] pressed 10 cycles later -> with BTN_ONEHOT_LOCK_EN: btn[0] suppressed, multi_press pulses; without: btn=3'b001 pulses.
REQ-030 reset pulsed 2 cycles after a btn_raw[1] press, button still held -> all outputs 0 during reset; one btn=3'b010 pulse 6 edges after reset deasserts.
REQ-031 btn_raw stays 3'b111 for 100 cycles after reset -> btn, btn_level, multi_press remain 0 throughout.

Source files
------------

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop sync, per-button debounce, one-hot press pulses.
// Optional BTN_ONEHOT_LOCK_EN rejects presses while another button is held.
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] btn_raw,
   output logic [2:0] btn,
   output logic [2:0] btn_level,
   output logic       multi_press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [2:0] sync1_q, sync2_q;
   logic [2:0] btn_sync;
   logic [2:0] toggle;
   logic [2:0] rise;
   logic [2:0] level_q, level_d;
   logic [2:0] btn_q, btn_d;
   logic       multi_q, multi_d;

   // Synchronizer flops idle at the released (high) level of the raw inputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 3'b111;
         sync2_q <= 3'b111;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   assign btn_sync = ~sync2_q;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_debounce
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             differs;

         assign differs     = btn_sync[gi] != level_q[gi];
         assign toggle[gi]  = differs && (cnt_q == CNT_LAST);
         assign cnt_d       = (!differs || toggle[gi]) ? '0 : cnt_q + CNT_W'(1);

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

   assign level_d = level_q ^ toggle;
   assign rise    = toggle & ~level_q;

   always_comb begin
      btn_d   = rise;
      multi_d = 1'b0;
`ifdef BTN_ONEHOT_LOCK_EN
      for (int i = 0; i < 3; i++) begin
         if (rise[i] && ((level_q & ~(3'b001 << i)) != 3'b000)) begin
            btn_d[i] = 1'b0;
            multi_d  = 1'b1;
         end
      end
`endif
      // Two or more simultaneous candidates: reject them all.
      if ((rise & (rise - 3'd1)) != 3'b000) begin
         btn_d   = 3'b000;
         multi_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level_q <= 3'b000;
         btn_q   <= 3'b000;
         multi_q <= 1'b0;
      end else begin
         level_q <= level_d;
         btn_q   <= btn_d;
         multi_q <= multi_d;
      end
   end

   assign btn         = btn_q;
   assign btn_level   = level_q;
   assign multi_press = multi_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner (DEBOUNCE_CYCLES=4, CNT_W=3).
module tb_btn_conditioner;

   logic       clk;
   logic       rst;
   logic [2:0] btn_raw;
   logic [2:0] btn;
   logic [2:0] btn_level;
   logic       multi_press;

   int checks = 0;
   int errors = 0;

   btn_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clock      (clk),
      .reset      (rst),
      .btn_raw    (btn_raw),
      .btn        (btn),
      .btn_level  (btn_level),
      .multi_press(multi_press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Release all buttons and confirm that releases never pulse.
   task automatic release_all(input string name);
      @(negedge clk);
      btn_raw = 3'b111;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++;
         if (btn !== 3'b000 || multi_press !== 1'b0) begin
            errors++;
            $display("FAIL %s_release cyc %0d: btn=%b multi=%b, want 000/0", name, k, btn, multi_press);
         end
      end
      checks++;
      if (btn_level !== 3'b000) begin
         errors++;
         $display("FAIL %s_release_level: btn_level=%b, want 000", name, btn_level);
      end
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      btn_raw = 3'b111;
      #2;
      checks++;
      if (btn !== 3'b000 || btn_level !== 3'b000 || multi_press !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: btn=%b level=%b multi=%b, want 000/000/0", btn, btn_level, multi_press);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_idle();
      for (int k = 1; k <= 100; k++) begin
         tick();
         checks++;
         if (btn !== 3'b000 || btn_level !== 3'b000 || multi_press !== 1'b0) begin
            errors++;
            $display("FAIL idle cyc %0d: btn=%b level=%b multi=%b, want all 0", k, btn, btn_level, multi_press);
         end
      end
   endtask

   task automatic test_clean_press();
      @(negedge clk);
      btn_raw = 3'b101;
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++;
         if (btn !== ((k == 6) ? 3'b010 : 3'b000)) begin
            errors++;
            $display("FAIL clean_btn cyc %0d: btn=%b, want %b", k, btn, (k == 6) ? 3'b010 : 3'b000);
         end
         checks++;
         if (btn_level !== ((k >= 6) ? 3'b010 : 3'b000) || multi_press !== 1'b0) begin
            errors++;
            $display("FAIL clean_level cyc %0d: level=%b multi=%b", k, btn_level, multi_press);
         end
      end
      release_all("clean");
   endtask

   task automatic test_bounce();
      for (int p = 0; p < 6; p++) begin
         @(negedge clk);
         btn_raw = (p % 2 == 0) ? 3'b110 : 3'b111;
         for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (btn !== 3'b000 || btn_level !== 3'b000) begin
               errors++;
               $display("FAIL bounce phase %0d: btn=%b level=%b, want 000/000", p, btn, btn_level);
            end
         end
      end
      @(negedge clk);
      btn_raw = 3'b110;
      for (int k = 1; k <= 12; k++) begin
         tick();
         checks++;
         if (btn !== ((k == 6) ? 3'b001 : 3'b000)) begin
            errors++;
            $display("FAIL bounce_settle cyc %0d: btn=%b, want %b", k, btn, (k == 6) ? 3'b001 : 3'b000);
         end
      end
      release_all("bounce");
   endtask

   task automatic test_same_cycle();
      @(negedge clk);
      btn_raw = 3'b010;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++;
         if (btn !== 3'b000 || multi_press !== (k == 6)) begin
            errors++;
            $display("FAIL same_cycle cyc %0d: btn=%b multi=%b, want 000/%b", k, btn, multi_press, k == 6);
         end
         checks++;
         if (btn_level !== ((k >= 6) ? 3'b101 : 3'b000)) begin
            errors++;
            $display("FAIL same_cycle_level cyc %0d: level=%b", k, btn_level);
         end
      end
      release_all("same");
   endtask

   task automatic test_overlap();
      @(negedge clk);
      btn_raw = 3'b011;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++;
         if (btn !== ((k == 6) ? 3'b100 : 3'b000) || multi_press !== 1'b0) begin
            errors++;
            $display("FAIL overlap_first cyc %0d: btn=%b multi=%b", k, btn, multi_press);
         end
      end
      @(negedge clk);
      btn_raw = 3'b010;
      for (int k = 1; k <= 10; k++) begin
         tick();
`ifdef BTN_ONEHOT_LOCK_EN
         checks++;
         if (btn !== 3'b000 || multi_press !== (k == 6)) begin
            errors++;
            $display("FAIL overlap_lock cyc %0d: btn=%b multi=%b, want 000/%b", k, btn, multi_press, k == 6);
         end
`else
         checks++;
         if (btn !== ((k == 6) ? 3'b001 : 3'b000) || multi_press !== 1'b0) begin
            errors++;
            $display("FAIL overlap_nolock cyc %0d: btn=%b multi=%b", k, btn, multi_press);
         end
`endif
         checks++;
         if (btn_level !== ((k >= 6) ? 3'b101 : 3'b100)) begin
            errors++;
            $display("FAIL overlap_level cyc %0d: level=%b", k, btn_level);
         end
      end
      release_all("overlap");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      btn_raw = 3'b101;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (btn !== 3'b000 || btn_level !== 3'b000 || multi_press !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_async: btn=%b level=%b multi=%b", btn, btn_level, multi_press);
      end
      for (int k = 1; k <= 2; k++) begin
         tick();
         checks++;
         if (btn !== 3'b000 || btn_level !== 3'b000 || multi_press !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold cyc %0d: btn=%b level=%b multi=%b", k, btn, btn_level, multi_press);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++;
         if (btn !== ((k == 6) ? 3'b010 : 3'b000)) begin
            errors++;
            $display("FAIL reset_mid_press cyc %0d: btn=%b, want %b", k, btn, (k == 6) ? 3'b010 : 3'b000);
         end
      end
      release_all("reset_mid");
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         btn_raw = 3'b011;
         for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (btn !== ((k == 6) ? 3'b100 : 3'b000)) begin
               errors++;
               $display("FAIL back_to_back rep %0d cyc %0d: btn=%b", r, k, btn);
            end
         end
         release_all("b2b");
      end
   endtask

   initial begin
      test_reset();
      $display("test_reset done");
      test_idle();
      $display("test_idle done");
      test_clean_press();
      $display("test_clean_press done");
      test_bounce();
      $display("test_bounce done");
      test_same_cycle();
      $display("test_same_cycle done");
      test_overlap();
      $display("test_overlap done");
      test_reset_mid();
      $display("test_reset_mid done");
      test_back_to_back();
      $display("test_back_to_back done");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
